// File: rtl/shot_turn_controller.sv
// shot_turn_controller: game-level shot/turn sequencer for the two-player billiard game.
// Samples cue controls once per frame, fires a one-cycle launch with signed x/y speeds,
// waits for all balls to settle, scores pocketed balls, switches turns and declares a winner.
//
// Latency: launchPulse rises in the cycle after the edge that samples shootKey release;
// score/currentPlayer/respawnCue update on the edge leaving evaluation.
// Backpressure: none; the block only reacts to startOfFrame and ball status levels.
//
// Optional feature macro: SHOT_TIMEOUT_EN (aim timeout that passes the turn after
// TIMEOUT_FRAMES idle frames in AIM). Undefined by default: AIM waits indefinitely.
//
// Ports:
//   clk, resetN                 clock, asynchronous active-low reset
//   startOfFrame                one-cycle frame pulse; all sampling/counting happens on it
//   shootKey, aimDir            cue controls (held = charge, release = fire; 8 directions)
//   ballStopped, ballKilled     per-ball status from the move logic (index 0 = cue ball)
//   launchPulse, launchX/YSpeed one-cycle launch command with registered speeds
//   respawnCue                  one-cycle cue-ball respawn request after a scratch
//   currentPlayer, score0/1     turn owner and per-player scores
//   power                       current charge level for the HUD
//   gameOver, winner, busy      end-of-game status; busy is high outside AIM

module shot_turn_controller #(
  parameter int NUM_BALLS      = 8,
  parameter int MIN_POWER      = 32,
  parameter int POWER_STEP     = 16,
  parameter int MAX_POWER      = 224,
  parameter int SETTLE_FRAMES  = 4,
  parameter int WIN_SCORE      = 4,
  parameter int TIMEOUT_FRAMES = 300
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 shootKey,
  input  logic [2:0]           aimDir,
  input  logic [NUM_BALLS-1:0] ballStopped,
  input  logic [NUM_BALLS-1:0] ballKilled,
  output logic                 launchPulse,
  output logic signed [31:0]   launchXSpeed,
  output logic signed [31:0]   launchYSpeed,
  output logic                 respawnCue,
  output logic                 currentPlayer,
  output logic [3:0]           score0,
  output logic [3:0]           score1,
  output logic [7:0]           power,
  output logic                 gameOver,
  output logic                 winner,
  output logic                 busy
);

  localparam int SC_W = $clog2(SETTLE_FRAMES + 1);
`ifdef SHOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
`endif

  typedef enum logic [2:0] {
    S_AIM,
    S_CHARGE,
    S_LAUNCH,
    S_ROLLING,
    S_SETTLE,
    S_EVALUATE,
    S_OVER
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            power_q, power_d;
  logic                  launch_q, launch_d;
  logic signed [31:0]    xspd_q, xspd_d;
  logic signed [31:0]    yspd_q, yspd_d;
  logic                  respawn_q, respawn_d;
  logic                  player_q, player_d;
  logic [3:0]            score0_q, score0_d;
  logic [3:0]            score1_q, score1_d;
  logic                  over_q, over_d;
  logic                  winner_q, winner_d;
  logic                  busy_q, busy_d;
  logic [NUM_BALLS-1:0]  mask_q, mask_d;
  logic [NUM_BALLS-1:0]  killed_prev_q;
  logic [1:0]            roll_cnt_q, roll_cnt_d;
  logic [SC_W-1:0]       settle_cnt_q, settle_cnt_d;
`ifdef SHOT_TIMEOUT_EN
  logic [TO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  // Shared datapath terms
  logic                  all_stopped;
  logic [NUM_BALLS-1:0]  kill_rise;
  logic [8:0]            power_sum;
  logic [7:0]            diag_mag;
  logic signed [31:0]    straight_spd;
  logic signed [31:0]    diag_spd;
  logic [7:0]            pocket_cnt;
  logic [7:0]            score_sum;
  logic [3:0]            cur_score;
  logic [3:0]            new_score;
  logic                  scratch;

  always_comb begin
    all_stopped  = &ballStopped;
    kill_rise    = ballKilled & ~killed_prev_q;
    power_sum    = {1'b0, power_q} + 9'(POWER_STEP);
    // 181/256 ~ 1/sqrt(2): diagonal magnitude keeps total speed close to power.
    diag_mag     = 8'(({8'd0, power_q} * 16'd181) >> 8);
    straight_spd = $signed({24'd0, power_q});
    diag_spd     = $signed({24'd0, diag_mag});
    // Only object balls score; the cue ball bit is the scratch flag.
    pocket_cnt   = '0;
    for (int i = 1; i < NUM_BALLS; i++) begin
      pocket_cnt = pocket_cnt + {7'd0, mask_q[i]};
    end
    cur_score    = player_q ? score1_q : score0_q;
    score_sum    = {4'd0, cur_score} + pocket_cnt;
    new_score    = (score_sum > 8'd15) ? 4'd15 : score_sum[3:0];
    scratch      = mask_q[0];
  end

  always_comb begin
    state_d      = state_q;
    power_d      = power_q;
    launch_d     = 1'b0;
    xspd_d       = '0;
    yspd_d       = '0;
    respawn_d    = 1'b0;
    player_d     = player_q;
    score0_d     = score0_q;
    score1_d     = score1_q;
    over_d       = over_q;
    winner_d     = winner_q;
    mask_d       = mask_q;
    roll_cnt_d   = roll_cnt_q;
    settle_cnt_d = settle_cnt_q;
`ifdef SHOT_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      S_AIM: begin
        power_d = 8'(MIN_POWER);
        if (startOfFrame) begin
          // A press while anything still rolls is simply ignored.
          if (shootKey && all_stopped) begin
            state_d = S_CHARGE;
          end
`ifdef SHOT_TIMEOUT_EN
          else if (int'(tmo_cnt_q) + 1 >= TIMEOUT_FRAMES) begin
            player_d  = ~player_q;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
`endif
        end
      end

      S_CHARGE: begin
        if (startOfFrame) begin
          if (shootKey) begin
            power_d = (power_sum > 9'(MAX_POWER)) ? 8'(MAX_POWER) : power_sum[7:0];
          end else begin
            // Release: speeds are registered together with the pulse.
            state_d  = S_LAUNCH;
            launch_d = 1'b1;
            case (aimDir)
              3'd0: begin xspd_d =  straight_spd; yspd_d = '0;            end
              3'd1: begin xspd_d =  diag_spd;     yspd_d =  diag_spd;     end
              3'd2: begin xspd_d = '0;            yspd_d =  straight_spd; end
              3'd3: begin xspd_d = -diag_spd;     yspd_d =  diag_spd;     end
              3'd4: begin xspd_d = -straight_spd; yspd_d = '0;            end
              3'd5: begin xspd_d = -diag_spd;     yspd_d = -diag_spd;     end
              3'd6: begin xspd_d = '0;            yspd_d = -straight_spd; end
              default: begin xspd_d = diag_spd;   yspd_d = -diag_spd;     end
            endcase
          end
        end
      end

      S_LAUNCH: begin
        mask_d       = '0;
        roll_cnt_d   = '0;
        settle_cnt_d = '0;
        state_d      = S_ROLLING;
      end

      S_ROLLING: begin
        mask_d = mask_q | kill_rise;
        if (startOfFrame) begin
          // The first two frames after launch are skipped so the move logic
          // has time to report the cue ball as moving.
          if (roll_cnt_q < 2'd2) begin
            roll_cnt_d = roll_cnt_q + 2'd1;
          end else if (all_stopped) begin
            // This frame is the first of the consecutive all-stopped run.
            settle_cnt_d = SC_W'(1);
            state_d      = (SETTLE_FRAMES <= 1) ? S_EVALUATE : S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        mask_d = mask_q | kill_rise;
        if (startOfFrame) begin
          if (!all_stopped) begin
            settle_cnt_d = '0;
            state_d      = S_ROLLING;
          end else if (int'(settle_cnt_q) + 1 >= SETTLE_FRAMES) begin
            state_d = S_EVALUATE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      S_EVALUATE: begin
        if (player_q) score1_d = new_score;
        else          score0_d = new_score;
        respawn_d = scratch;
        // Scratch always passes the turn; otherwise only an empty shot does.
        if (scratch || (pocket_cnt == 8'd0)) begin
          player_d = ~player_q;
        end
        if ({4'd0, new_score} >= 8'(WIN_SCORE)) begin
          over_d   = 1'b1;
          winner_d = player_q;
          state_d  = S_OVER;
        end else begin
          state_d  = S_AIM;
          power_d  = 8'(MIN_POWER);
        end
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_AIM;
      end
    endcase

`ifdef SHOT_TIMEOUT_EN
    if (state_d != S_AIM) begin
      tmo_cnt_d = '0;
    end
`endif

    busy_d = (state_d != S_AIM);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_AIM;
      power_q       <= 8'(MIN_POWER);
      launch_q      <= 1'b0;
      xspd_q        <= '0;
      yspd_q        <= '0;
      respawn_q     <= 1'b0;
      player_q      <= 1'b0;
      score0_q      <= '0;
      score1_q      <= '0;
      over_q        <= 1'b0;
      winner_q      <= 1'b0;
      busy_q        <= 1'b0;
      mask_q        <= '0;
      killed_prev_q <= '0;
      roll_cnt_q    <= '0;
      settle_cnt_q  <= '0;
`ifdef SHOT_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      power_q       <= power_d;
      launch_q      <= launch_d;
      xspd_q        <= xspd_d;
      yspd_q        <= yspd_d;
      respawn_q     <= respawn_d;
      player_q      <= player_d;
      score0_q      <= score0_d;
      score1_q      <= score1_d;
      over_q        <= over_d;
      winner_q      <= winner_d;
      busy_q        <= busy_d;
      mask_q        <= mask_d;
      killed_prev_q <= ballKilled;
      roll_cnt_q    <= roll_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
`ifdef SHOT_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign launchPulse   = launch_q;
  assign launchXSpeed  = xspd_q;
  assign launchYSpeed  = yspd_q;
  assign respawnCue    = respawn_q;
  assign currentPlayer = player_q;
  assign score0        = score0_q;
  assign score1        = score1_q;
  assign power         = power_q;
  assign gameOver      = over_q;
  assign winner        = winner_q;
  assign busy          = busy_q;

endmodule

// File: doc/shot_turn_controller.md
# shot_turn_controller

Game-level sequencer that sits above the per-ball move logic and drives the shot/turn cycle of the two-player billiard game. It samples the cue controls (aim, charge, shoot) once per frame, and issues a one-cycle launch command with signed x/y speeds to the cue ball's move logic. It then waits for every ball to come to rest and scores pocketed balls. Finally it switches turns, requests cue-ball respawn on a scratch, and declares the winner.

## Interface
Parameters:
- NUM_BALLS, 8, total balls; index 0 is the cue ball, 1..NUM_BALLS-1 are object balls
- MIN_POWER, 32, launch power at start of charge (fixed-point speed units, 1/64 px per frame)
- POWER_STEP, 16, power added per charging frame
- MAX_POWER, 224, power saturation value
- SETTLE_FRAMES, 4, consecutive all-stopped frames required before evaluation
- WIN_SCORE, 4, score that ends the game
- TIMEOUT_FRAMES, 300, aim timeout in frames (used only with SHOT_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame; all key sampling and frame counters advance only on it
- shootKey  in  1  level; held = charge, release = fire
- aimDir  in  3  direction code 0..7, 45° steps: 0=+x, 1=+x+y, 2=+y, 3=−x+y, 4=−x, 5=−x−y, 6=−y, 7=+x−y (y grows downward)
- ballStopped  in  NUM_BALLS  per-ball stopPlayBall; pocketed balls hold 1
- ballKilled  in  NUM_BALLS  per-ball killBall level
- launchPulse  out  1  one-cycle command to cue-ball move logic
- launchXSpeed, launchYSpeed  out  32 signed  speeds valid while launchPulse=1, else 0
- respawnCue  out  1  one-cycle pulse requesting cue-ball reset to start position
- currentPlayer  out  1  0 or 1
- score0, score1  out  4  per-player scores
- power  out  8  current charge level, for the HUD
- gameOver  out  1  level, set on win
- winner  out  1  valid while gameOver=1
- busy  out  1  1 in every state except AIM

## Operation
- States:
  - AIM → CHARGE → LAUNCH → ROLLING → SETTLE → EVALUATE → AIM
  - EVALUATE → OVER on win
- AIM: power=MIN_POWER.
  - On startOfFrame with shootKey=1 and all ballStopped=1 → CHARGE.
  - shootKey=1 while any ball is moving is ignored.
- CHARGE: each startOfFrame with shootKey=1 sets power=min(power+POWER_STEP, MAX_POWER). A startOfFrame with shootKey=0 → LAUNCH.
- LAUNCH: held for exactly one cycle.
  - launchPulse=1.
  - Cardinal directions: magnitude=power.
  - Diagonal directions: magnitude=(power*181)>>8, unsigned, computed before sign is applied.
  - Signs are taken from aimDir.
  - Clear the turn's pocketedMask. Then → ROLLING.
- ROLLING: wait at least 2 startOfFrames so the move logic can register motion. Then the first startOfFrame with all ballStopped=1 → SETTLE.
- SETTLE: counts consecutive all-stopped frames.
  - Any ballStopped=0 on a startOfFrame → back to ROLLING with the count cleared.
  - Count reaching SETTLE_FRAMES → EVALUATE.
- Pocket tracking, during ROLLING and SETTLE only: a rising edge of ballKilled[i] sets pocketedMask[i]. Edges in other states are ignored.
- EVALUATE: held for one cycle.
  - n = popcount(pocketedMask[NUM_BALLS-1:1]); add n to the current player's score, saturating at 15.
  - pocketedMask[0]=1 (scratch): respawnCue pulses, and the turn switches even if n>0.
  - Otherwise the turn switches iff n=0.
  - Updated score ≥ WIN_SCORE: gameOver=1, winner=currentPlayer (pre-switch) → OVER.
  - Otherwise → AIM.
- OVER: terminal state; only reset exits it.

## Timing
- Reset values:
  - state AIM, power=MIN_POWER
  - all pulses 0, launch speeds 0
  - currentPlayer=0, scores 0, gameOver=0, winner=0, busy=0, pocketedMask=0
- Fire latency: launchPulse is asserted in the cycle after the clock edge of the startOfFrame that sampled release.
- Speeds are registered; they are valid only in the launchPulse cycle.
- Score, currentPlayer and respawnCue all update on the same edge that leaves EVALUATE.
- Reset mid-shot aborts immediately. No pulse may be emitted after reset deassertion until a new shot is fired.
- Simultaneous events:
  - Cue and object ball pocketed in the same turn: score the object ball, respawn the cue ball, switch turn.
  - Edges on two balls in the same cycle: both are recorded.

## Configuration
- SHOT_TIMEOUT_EN defined: in AIM, a frame counter increments each startOfFrame and resets on leaving AIM. Reaching TIMEOUT_FRAMES switches currentPlayer, clears the counter and stays in AIM, with no score change.
- SHOT_TIMEOUT_EN not defined: the counter does not exist, and AIM waits indefinitely.

## Test plan
- shootKey held for 3 frames, then released, aimDir=0, all balls stopped → one launchPulse; launchXSpeed=80, launchYSpeed=0; then busy=1.
- Same charge with aimDir=5 → launchXSpeed=−56, launchYSpeed=−56.
- Hold shootKey for 20 frames → power saturates at 224 and never exceeds it.
- Shot with ballKilled[3] and ballKilled[5] rising during ROLLING, then all stopped for 4 frames → score0=2, currentPlayer stays 0.
- Shot with ballKilled[0] and ballKilled[2] rising → score0=1, respawnCue pulses once, currentPlayer=1.
- score1=3 and player 1 pockets one ball → gameOver=1, winner=1; later shootKey activity produces no launchPulse.
- Assert resetN low mid-ROLLING → all outputs at their reset values.
- With SHOT_TIMEOUT_EN: 300 idle frames in AIM → currentPlayer toggles.
